// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: shared register map, CTRL bit positions and register
// layouts for the Wishbone timer peripheral.
package wb_timer_pkg;

    // Word offsets, indexed by adr[4:2]
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_COUNT   = 3'd2;
    localparam logic [2:0] REG_COMPARE = 3'd3;
    localparam logic [2:0] REG_CAPTURE = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN         = 0;
    localparam int CTRL_IRQ_EN     = 1;
    localparam int CTRL_AUTORELOAD = 2;

    typedef struct packed {
        logic autoreload;
        logic irq_en;
        logic en;
    } ctrl_t;

    typedef struct packed {
        logic cap;
        logic match;
    } status_t;

    // Expand byte-lane selects into a 32-bit bit mask
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/if_wb.sv
// if_wb: 32-bit pipelined Wishbone bundle.
//   master drives adr, cyc, stb, we, sel, dat_m
//   slave  drives dat_s, ack, stall
interface if_wb;
    logic [31:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        stall;

    modport slave  (input  adr, cyc, stb, we, sel, dat_m,
                    output dat_s, ack, stall);
    modport master (output adr, cyc, stb, we, sel, dat_m,
                    input  dat_s, ack, stall);
endinterface

// File: rtl/wb_timer_prescaler.sv
// wb_timer_prescaler: divides the clock by PRESCALE while enabled.
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   en     - count enable (counter holds when low)
//   clear  - restart the divider at 0 (takes priority over counting)
//   tick   - one-cycle pulse on the cycle the divider wraps
module wb_timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(PRESCALE) + 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] r_cnt;

    assign tick = en && (r_cnt == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/wb_timer.sv
// wb_timer: pipelined Wishbone slave with a prescaled free-running 32-bit
// timer, compare match and level interrupt.
//   clk_i     - clock
//   rst_i     - synchronous active-high reset
//   bus       - if_wb slave (adr[4:2] decoded, stall tied low)
//   irq       - STATUS.match && CTRL.irq_en
//   capture_i - capture strobe, used only with WB_TIMER_CAPTURE_EN
// Optional macro WB_TIMER_CAPTURE_EN builds the capture register and
// STATUS.cap; without it CAPTURE and STATUS.cap read 0.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int          PRESCALE      = 1,
    parameter logic [31:0] RESET_COMPARE = 32'hffffffff
) (
    input  logic clk_i,
    input  logic rst_i,
    if_wb.slave  bus,
    output logic irq,
    input  logic capture_i
);
    ctrl_t       r_ctrl;
    logic        r_match;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ack_q;
    logic [31:0] r_rdata;

    logic        w_acc, w_wr, w_tick, w_hit, w_ack, w_cap_flag;
    logic        w_wr_ctrl, w_wr_status, w_wr_count, w_wr_compare;
    logic [2:0]  w_off;
    logic [31:0] w_mask, w_rdata, w_count_inc, w_capture;
    logic [2:0]  w_ctrl_new;
    logic [1:0]  w_clr;

    // Only adr[4:2] is decoded
    logic w_unused_adr;
    assign w_unused_adr = ^{bus.adr[31:5], bus.adr[1:0]};

    assign w_acc        = bus.cyc && bus.stb;
    assign w_wr         = w_acc && bus.we;
    assign w_off        = bus.adr[4:2];
    assign w_mask       = sel_mask(bus.sel);
    assign w_wr_ctrl    = w_wr && (w_off == REG_CTRL);
    assign w_wr_status  = w_wr && (w_off == REG_STATUS);
    assign w_wr_count   = w_wr && (w_off == REG_COUNT);
    assign w_wr_compare = w_wr && (w_off == REG_COMPARE);

    assign w_ctrl_new = (r_ctrl & ~w_mask[2:0]) | (bus.dat_m[2:0] & w_mask[2:0]);
    assign w_clr      = w_wr_status ? (bus.dat_m[1:0] & w_mask[1:0]) : 2'b00;

    wb_timer_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (r_ctrl.en),
        .clear (w_wr_count),
        .tick  (w_tick)
    );

    // Match only on a real increment; a COUNT write suppresses the increment
    assign w_count_inc = r_count + 32'd1;
    assign w_hit       = w_tick && !w_wr_count && (w_count_inc == r_compare);

    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_CTRL:    w_rdata = {29'd0, r_ctrl};
            REG_STATUS:  w_rdata = {30'd0, w_cap_flag, r_match};
            REG_COUNT:   w_rdata = r_count;
            REG_COMPARE: w_rdata = r_compare;
            REG_CAPTURE: w_rdata = w_capture;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl    <= '0;
            r_match   <= 1'b0;
            r_count   <= '0;
            r_compare <= RESET_COMPARE;
            r_ack_q   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_ack_q <= w_acc;
            r_rdata <= w_acc ? w_rdata : '0;
            if (w_wr_ctrl) begin
                r_ctrl.en         <= w_ctrl_new[CTRL_EN];
                r_ctrl.irq_en     <= w_ctrl_new[CTRL_IRQ_EN];
                r_ctrl.autoreload <= w_ctrl_new[CTRL_AUTORELOAD];
            end
            if (w_wr_compare)
                r_compare <= (r_compare & ~w_mask) | (bus.dat_m & w_mask);
            if (w_wr_count)
                r_count <= (r_count & ~w_mask) | (bus.dat_m & w_mask);
            else if (w_tick)
                r_count <= (w_hit && r_ctrl.autoreload) ? '0 : w_count_inc;
            // set beats W1C
            r_match <= w_hit | (r_match & ~w_clr[0]);
        end
    end

`ifdef WB_TIMER_CAPTURE_EN
    logic        r_cap_prev, r_cap;
    logic [31:0] r_capture;
    logic        w_cap_edge;

    assign w_cap_edge = capture_i && !r_cap_prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cap_prev <= 1'b0;
            r_cap      <= 1'b0;
            r_capture  <= '0;
        end else begin
            r_cap_prev <= capture_i;
            // r_count here is the pre-write value of this cycle
            if (w_cap_edge)
                r_capture <= r_count;
            r_cap <= w_cap_edge | (r_cap & ~w_clr[1]);
        end
    end

    assign w_cap_flag = r_cap;
    assign w_capture  = r_capture;
`else
    logic w_unused_cap;
    assign w_unused_cap = capture_i ^ w_clr[1];
    assign w_cap_flag   = 1'b0;
    assign w_capture    = '0;
`endif

    // Abort drops a pending response: ack qualified by the live cyc
    assign w_ack     = r_ack_q && bus.cyc;
    assign bus.ack   = w_ack;
    assign bus.dat_s = w_ack ? r_rdata : '0;
    assign bus.stall = 1'b0;
    assign irq       = r_match && r_ctrl.irq_en;

endmodule

// File: tb/tb_wb_timer.sv
module tb_wb_timer;
    localparam int PRESCALE = 4;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    logic capture;
    if_wb wb ();

    wb_timer #(.PRESCALE(PRESCALE)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (wb),
        .irq       (irq),
        .capture_i (capture)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: spec-level register state
    logic [2:0]  m_ctrl;      // {autoreload, irq_en, en}
    logic        m_match, m_cap, m_capprev, m_ackq;
    logic [31:0] m_count, m_cmp, m_capt, m_rdata;
    int          m_pre;

    task automatic m_reset();
        m_ctrl = 0; m_match = 0; m_cap = 0; m_capprev = 0; m_ackq = 0;
        m_count = 0; m_cmp = 32'hffffffff; m_capt = 0; m_rdata = 0; m_pre = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0: return {29'd0, m_ctrl};
            3'd1: return {30'd0, m_cap, m_match};
            3'd2: return m_count;
            3'd3: return m_cmp;
            3'd4: return m_capt;
            default: return 32'd0;
        endcase
    endfunction

    // One bus clock: drive, check outputs of the current state, advance model
    task automatic cyc1(input logic r, input logic c, input logic s, input logic w,
                        input logic [2:0] off, input logic [3:0] sel,
                        input logic [31:0] dat, input logic cp);
        logic [31:0] mask, nxt_count, clr;
        logic        inc, hit, edge_;
        rst = r; wb.cyc = c; wb.stb = s; wb.we = w; wb.sel = sel; wb.dat_m = dat;
        wb.adr = {$urandom_range(0, 3) == 0 ? 27'h5a5a5a5 : 27'd0, off, 2'b00};
        capture = cp;
        @(negedge clk);
        chk("ack",   {31'd0, wb.ack},   {31'd0, m_ackq && c});
        chk("dat_s", wb.dat_s,          (m_ackq && c) ? m_rdata : 32'd0);
        chk("irq",   {31'd0, irq},      {31'd0, m_match && m_ctrl[1]});
        chk("stall", {31'd0, wb.stall}, 32'd0);
        if (r) begin
            m_reset();
        end else begin
            mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            m_ackq  = c && s;
            m_rdata = (c && s) ? m_read(off) : 32'd0;
            inc = 0; hit = 0;
            if (m_ctrl[0]) begin
                if (m_pre == PRESCALE - 1) begin inc = 1; m_pre = 0; end
                else m_pre = m_pre + 1;
            end
            nxt_count = m_count;
            if (c && s && w && off == 3'd2) begin
                nxt_count = (m_count & ~mask) | (dat & mask);
                m_pre = 0;
            end else if (inc) begin
                nxt_count = m_count + 32'd1;
                if (nxt_count == m_cmp) begin
                    hit = 1;
                    if (m_ctrl[2]) nxt_count = 0;
                end
            end
`ifdef WB_TIMER_CAPTURE_EN
            edge_ = cp && !m_capprev;
`else
            edge_ = 0;
`endif
            m_capprev = cp;
            if (edge_) m_capt = m_count;
            clr = (c && s && w && off == 3'd1) ? (dat & mask) : 32'd0;
            m_match = hit   || (m_match && !clr[0]);
            m_cap   = edge_ || (m_cap && !clr[1]);
            if (c && s && w && off == 3'd0 && sel[0]) m_ctrl = dat[2:0];
            if (c && s && w && off == 3'd3) m_cmp = (m_cmp & ~mask) | (dat & mask);
            m_count = nxt_count;
        end
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] dat, input logic [3:0] sel = 4'hf);
        cyc1(0, 1, 1, 1, off, sel, dat, 0);
    endtask
    task automatic rd(input logic [2:0] off);
        cyc1(0, 1, 1, 0, off, 4'hf, 32'd0, 0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc1(0, 1, 0, 0, 3'd0, 4'hf, 32'd0, 0);
    endtask

    initial begin
        rst = 1; wb.cyc = 0; wb.stb = 0; wb.we = 0; wb.adr = 0; wb.sel = 0;
        wb.dat_m = 0; capture = 0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        cyc1(1, 0, 0, 0, 3'd0, 4'h0, 32'd0, 0);

        // Reset values, all offsets read back to back
        for (int i = 0; i < 8; i++) rd(3'(i));
        idle(2);

        // Compare 3, en + irq_en
        wr(3'd3, 32'd3);
        wr(3'd0, 32'd3);
        for (int i = 0; i < 20; i++) rd(3'd2);

        // Autoreload at compare 2, then W1C
        cyc1(1, 0, 0, 0, 3'd0, 4'h0, 32'd0, 0);
        wr(3'd3, 32'd2);
        wr(3'd0, 32'd7);
        for (int i = 0; i < 16; i++) rd(3'd2);
        rd(3'd1);
        wr(3'd1, 32'd1);
        idle(2);

        // Partial COUNT write while counting, then rollover
        wr(3'd0, 32'd1);
        idle(2);
        wr(3'd2, 32'h0000ab00, 4'b0010);
        for (int i = 0; i < 6; i++) rd(3'd2);
        wr(3'd2, 32'hffffffff);
        for (int i = 0; i < 6; i++) rd(3'd2);

        // W1C hammered while matches keep arriving
        wr(3'd3, 32'd1);
        wr(3'd0, 32'd7);
        for (int i = 0; i < 14; i++) wr(3'd1, 32'd1);
        rd(3'd1);

        // Abort: stb then cyc dropped
        rd(3'd3);
        cyc1(0, 0, 0, 0, 3'd0, 4'hf, 32'd0, 0);

        // Capture pulse around COUNT
        wr(3'd2, 32'd5);
        wr(3'd0, 32'd0);
        cyc1(0, 1, 0, 0, 3'd0, 4'hf, 32'd0, 1);
        cyc1(0, 1, 0, 0, 3'd0, 4'hf, 32'd0, 0);
        rd(3'd4);
        rd(3'd1);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [2:0]  off;
            logic [31:0] dat;
            off = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       dat = 32'hffffffff - 32'($urandom_range(0, 3));
                1:       dat = $urandom;
                default: dat = 32'($urandom_range(0, 12));
            endcase
            cyc1($urandom_range(0, 399) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0,
                 off, 4'($urandom), dat,
                 $urandom_range(0, 5) == 0);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
